// File: rtl/lcd_bus_scheduler.sv
// Write-only HD44780-style LCD bus scheduler: arbitrates two requesters (0 has fixed priority)
// and generates RS/E setup, enable-pulse, hold and execution-wait timing for each byte.
module lcd_bus_scheduler #(
  parameter int unsigned SETUP_CYC      = 3,
  parameter int unsigned E_HIGH_CYC     = 25,
  parameter int unsigned HOLD_CYC       = 3,
  parameter int unsigned CMD_WAIT_CYC   = 2500,
  parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy
);

  localparam int unsigned MAX_AB  = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int unsigned MAX_ABC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int unsigned MAX_W   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int unsigned MAX_CYC = (MAX_ABC > MAX_W) ? MAX_ABC : MAX_W;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] E_LD     = CW'(E_HIGH_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CMD_LD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_WAIT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          clear_cmd;
  logic [CW-1:0] wait_ld;

  assign lcd_rw = 1'b0;

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  always_comb begin
    clear_cmd = !lcd_rs && (lcd_data[7:2] == '0) && (lcd_data != '0);
    wait_ld   = clear_cmd ? CLEAR_LD : CMD_LD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_data <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            if (req0) begin
              lcd_rs   <= rs0;
              lcd_data <= data0;
              owner    <= 1'b0;
            end else begin
              lcd_rs   <= rs1;
              lcd_data <= data1;
              owner    <= 1'b1;
            end
            cnt   <= SETUP_LD;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt   <= E_LD;
            lcd_e <= 1'b1;
            state <= PULSE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            cnt   <= HOLD_LD;
            lcd_e <= 1'b0;
            state <= HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= wait_ld;
            state <= WAIT;
            // A one-cycle wait means the first WAIT cycle is already the ack cycle.
            if (wait_ld == '0) begin
              ack0 <= !owner;
              ack1 <= owner;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              ack0 <= !owner;
              ack1 <= owner;
            end
          end
        end
        default: begin
          lcd_e <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed bench for lcd_bus_scheduler with SETUP=2, E_HIGH=4, HOLD=2, CMD_WAIT=10, CLEAR_WAIT=40.
module tb_lcd_bus_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, rs0, req1, rs1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, lcd_rs, lcd_rw, lcd_e, busy;
  logic [7:0] lcd_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] e_v, a0_v, a1_v, b_v, rs_v, rw_v;
  logic [7:0]   d_h [0:127];

  always #5 clk = ~clk;

  lcd_bus_scheduler #(
    .SETUP_CYC(2), .E_HIGH_CYC(4), .HOLD_CYC(2), .CMD_WAIT_CYC(10), .CLEAR_WAIT_CYC(40)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Records n cycles (cycle 0 = first cycle after the grant edge), sampled on the falling edge.
  task automatic capture(input int n, input bit drop0, input int drop1_after,
                         input int poke_cyc, input logic [7:0] poke_val);
    int acks1 = 0;
    e_v = '0; a0_v = '0; a1_v = '0; b_v = '0; rs_v = '0; rw_v = '0;
    for (int c = 0; c < 128; c++) d_h[c] = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      e_v[c] = lcd_e; a0_v[c] = ack0; a1_v[c] = ack1; b_v[c] = busy;
      rs_v[c] = lcd_rs; rw_v[c] = lcd_rw; d_h[c] = lcd_data;
      if (c == poke_cyc) begin
        data1 = poke_val;
        rs1   = ~rs1;
      end
      if (drop0 && ack0) req0 = 1'b0;
      if (ack1) begin
        acks1++;
        if (acks1 == drop1_after) req1 = 1'b0;
      end
    end
  endtask

  function automatic int count_data(input logic [7:0] v, input int last);
    int k = 0;
    for (int c = 0; c <= last; c++) if (d_h[c] == v) k++;
    return k;
  endfunction

  initial begin
    reset = 1'b1; req0 = 0; rs0 = 0; data0 = '0; req1 = 0; rs1 = 0; data1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_vals", {lcd_rs, lcd_rw, lcd_e, lcd_data, ack0, ack1, busy}, '0);
    reset = 1'b0;
    @(negedge clk);

    // Single data write from requester 1
    req1 = 1; rs1 = 1; data1 = 8'h41;
    capture(30, 0, 1, -1, 8'h00);
    chk("t1_e", e_v[31:0], 128'h3C);
    chk("t1_ack1", a1_v[31:0], 128'h20000);
    chk("t1_ack0", a0_v[31:0], 128'h0);
    chk("t1_busy", b_v[31:0], 128'h3FFFF);
    chk("t1_rs", rs_v[17:0], 128'h3FFFF);
    chk("t1_rw", rw_v[31:0], 128'h0);
    chk("t1_data", count_data(8'h41, 17), 18);

    // Clear command: long wait
    req0 = 1; rs0 = 0; data0 = 8'h01;
    capture(60, 1, 0, -1, 8'h00);
    chk("t2_clear_ack0", a0_v[63:0], 128'd1 << 47);
    chk("t2_busy_edge", b_v[48:47], 128'b01);
    chk("t2_ack1", a1_v[63:0], 128'h0);

    // Home (0x03) also long; function-set 0x38 and 0x00 use the normal wait
    req0 = 1; data0 = 8'h03;
    capture(60, 1, 0, -1, 8'h00);
    chk("t2_home_ack0", a0_v[63:0], 128'd1 << 47);
    req0 = 1; data0 = 8'h38;
    capture(30, 1, 0, -1, 8'h00);
    chk("t2_cmd_ack0", a0_v[31:0], 128'd1 << 17);
    req0 = 1; data0 = 8'h00;
    capture(30, 1, 0, -1, 8'h00);
    chk("t2_zero_ack0", a0_v[31:0], 128'd1 << 17);
    req0 = 1; rs0 = 1; data0 = 8'h01;
    capture(30, 1, 0, -1, 8'h00);
    chk("t2_data01_ack0", a0_v[31:0], 128'd1 << 17);

    // Simultaneous requests: requester 0 first, requester 1 after req0 drops
    req0 = 1; rs0 = 0; data0 = 8'h55; req1 = 1; rs1 = 1; data1 = 8'h66;
    capture(45, 1, 1, -1, 8'h00);
    chk("t3_ack0", a0_v[63:0], 128'd1 << 17);
    chk("t3_ack1", a1_v[63:0], 128'd1 << 36);
    chk("t3_data_first", d_h[0], 8'h55);
    chk("t3_data_second", d_h[19], 8'h66);
    chk("t3_rs", {rs_v[19], rs_v[0]}, 128'b10);
    chk("t3_busy_gap", b_v[19:17], 128'b101);

    // Payload change during PULSE is ignored
    req1 = 1; rs1 = 1; data1 = 8'h41;
    capture(30, 0, 1, 3, 8'h42);
    chk("t4_data", count_data(8'h41, 17), 18);
    chk("t4_rs", rs_v[17:0], 128'h3FFFF);
    chk("t4_ack1", a1_v[31:0], 128'd1 << 17);

    // Streaming three bytes from requester 1
    req1 = 1; rs1 = 1; data1 = 8'h30;
    capture(70, 0, 3, -1, 8'h00);
    chk("t5_ack1", a1_v[69:0], (128'd1 << 17) | (128'd1 << 36) | (128'd1 << 55));
    chk("t5_e", e_v[69:0], 128'h3C | (128'h3C << 19) | (128'h3C << 38));
    chk("t5_ack0", a0_v[69:0], 128'h0);

    // Reset during PULSE discards the transaction
    req1 = 1; rs1 = 1; data1 = 8'h77;
    repeat (3) @(negedge clk);
    chk("t6_in_pulse", {lcd_e, busy, lcd_data}, {2'b11, 8'h77});
    reset = 1; req1 = 0;
    @(negedge clk);
    chk("t6_after_reset", {lcd_rs, lcd_rw, lcd_e, lcd_data, ack0, ack1, busy}, '0);
    reset = 0;
    capture(25, 0, 1, -1, 8'h00);
    chk("t6_no_ack", a0_v[24:0] | a1_v[24:0] | b_v[24:0], 128'h0);
    req0 = 1; rs0 = 0; data0 = 8'h38;
    capture(30, 1, 0, -1, 8'h00);
    chk("t6_new_ack0", a0_v[31:0], 128'd1 << 17);
    chk("t6_new_e", e_v[31:0], 128'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_bus_scheduler.md
# lcd_bus_scheduler

Write-only transaction scheduler for the shared HD44780-style character LCD bus on the 50 MHz calculator board. It arbitrates between two requesters, the power-up initializer (requester 0) and the display refresh driver (requester 1), and serializes their command/data bytes. For each byte it generates RS/RW/E with the required setup, enable-pulse, hold and execution-wait timing. It replaces ad-hoc muxing of initializer and driver bus signals.

## Interface
- SETUP_CYC, 3: cycles RS/DATA are stable before E rises (≥1)
- E_HIGH_CYC, 25: E high duration in cycles (≥1)
- HOLD_CYC, 3: cycles RS/DATA are held after E falls (≥1)
- CMD_WAIT_CYC, 2500: execution wait after a normal command or data write (≥1)
- CLEAR_WAIT_CYC, 82000: execution wait after clear/home commands (≥1)
- clk  in  1  50 MHz system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 (initializer) transaction request
- rs0  in  1  requester 0 register select (0 = command, 1 = data)
- data0  in  8  requester 0 byte
- ack0  out  1  one-cycle pulse: requester 0 transaction complete
- req1, rs1, data1, ack1: same as above, for requester 1 (refresh driver)
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; constant 0
- lcd_e  out  1  LCD enable strobe
- lcd_data  out  8  LCD data bus, write direction only
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE → SETUP → PULSE → HOLD → WAIT → IDLE.
- IDLE:
  - Sample req0/req1. Fixed priority: req0 wins when both are high.
  - On grant, latch the winner's rs/data into lcd_rs/lcd_data, record the winner's index, load the counter and go to SETUP.
  - With no request, stay in IDLE. lcd_rs/lcd_data keep their last values.
- SETUP: lcd_e=0 for SETUP_CYC cycles, then go to PULSE.
- PULSE: lcd_e=1 for E_HIGH_CYC cycles, then go to HOLD.
- HOLD: lcd_e=0 for HOLD_CYC cycles, then go to WAIT.
- WAIT:
  - Count CLEAR_WAIT_CYC if the latched rs=0 and data[7:2]=0 with data≠0 (clear 0x01, home 0x02/0x03).
  - Otherwise count CMD_WAIT_CYC.
  - During the final WAIT cycle, assert ack for the granted requester only, then go to IDLE.
- lcd_rs and lcd_data stay constant from grant through the end of WAIT. Changes on rs*/data* after grant are ignored.
- Requester contract:
  - Hold req and the payload stable until ack is seen.
  - Req still high in the cycle after ack is a new transaction.
  - Req held high continuously streams back-to-back bytes.
- Starvation: requester 1 is only served when req0 is low in IDLE. This is acceptable because the initializer finishes once.
- Dropping req mid-transaction has no effect: the transaction completes and the ack still pulses.
- lcd_rw is tied 0 permanently. No busy-flag readback; timing is purely counter-based.
- Counter width must hold max(all *_CYC). Size it with $clog2(CLEAR_WAIT_CYC+1) or larger.

## Timing
- Reset values: lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_data=8'h00, ack0=0, ack1=0, busy=0, state=IDLE.
- Reset mid-transaction: all outputs return to reset values on the next edge. The transaction is discarded and no ack is issued.
- Grant edge = edge at which IDLE sees a request. busy is high from the cycle after the grant edge.
- lcd_e rises SETUP_CYC cycles after the grant edge and stays high for exactly E_HIGH_CYC cycles.
- ack occurs in cycle SETUP_CYC+E_HIGH_CYC+HOLD_CYC+WAIT−1 counted after the grant edge, with cycle 0 = first SETUP cycle. busy deasserts the following cycle.
- Minimum request-to-request spacing for a streaming requester = SETUP+E_HIGH+HOLD+WAIT+1 cycles.
- ack0 and ack1 are never high together. Each is high for exactly one cycle per transaction.

## Test plan
Use SETUP=2, E_HIGH=4, HOLD=2, CMD_WAIT=10, CLEAR_WAIT=40.
- Single data write: req1=1, rs1=1, data1=8'h41.
  - Required: lcd_rs=1, lcd_data=8'h41 from cycle 0; lcd_e high cycles 2–5.
  - Required: ack1 pulse in cycle 17; busy low in cycle 18; ack0 never asserted.
- Clear command: req0=1, rs0=0, data0=8'h01.
  - Required: ack0 pulse in cycle 47.
  - Repeat with data0=8'h38: ack0 pulse in cycle 17.
- Simultaneous requests: req0=req1=1 held.
  - Required: requester 0 is served first (lcd_data=data0); requester 1 is served only after req0 drops following ack0.
- Payload change mid-transaction: change data1 from 8'h41 to 8'h42 while in PULSE.
  - Required: lcd_data stays 8'h41 through WAIT.
- Streaming: hold req1 high for 3 bytes.
  - Required: 3 ack1 pulses spaced 19 cycles apart; lcd_e low between pulses.
- Reset mid-transaction: assert reset during PULSE.
  - Required: next cycle lcd_e=0, lcd_data=8'h00, busy=0, no ack.
  - Required: a new request after reset completes normally.
